// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its dead-time gate-drive stage.
package pwm_pkg;

  localparam int unsigned PWM_DT_W_DEFAULT = 8;
  localparam int unsigned PWM_PERIOD       = 255;

  // Flop index of each one-hot state, so outputs can tap a single flop.
  localparam int unsigned PWM_DT_OFF_BIT   = 0;
  localparam int unsigned PWM_DT_TO_HS_BIT = 1;
  localparam int unsigned PWM_DT_HS_ON_BIT = 2;
  localparam int unsigned PWM_DT_TO_LS_BIT = 3;
  localparam int unsigned PWM_DT_LS_ON_BIT = 4;
  localparam int unsigned PWM_DT_FAULT_BIT = 5;

  typedef enum logic [5:0] {
    PWM_DT_OFF   = 6'b00_0001,
    PWM_DT_TO_HS = 6'b00_0010,
    PWM_DT_HS_ON = 6'b00_0100,
    PWM_DT_TO_LS = 6'b00_1000,
    PWM_DT_LS_ON = 6'b01_0000,
    PWM_DT_FAULT = 6'b10_0000
  } pwm_dt_state_e;

endpackage

// File: rtl/pwm_deadtime_dt_timer.sv
// Dead-time down-counter: loads a count on request, then decrements and
// saturates at zero; expired reads true once the count has reached zero.
module dt_timer #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DT_W-1:0] value,
  output logic            expired
);

  logic [DT_W-1:0] count_q;

  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - DT_W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low-side gate drive with programmable dead time on every
// changeover, drive enable and a latched fault shutdown.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = PWM_DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DT_W-1:0] dead_cycles,
  input  logic            pwm_in,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            hs_out,
  output logic            ls_out,
  output logic            dt_active,
  output logic            fault_flag
);

  pwm_dt_state_e   state_q;
  pwm_dt_state_e   state_next;
  logic            pwm_q;
  logic            dt_load;
  logic            dt_expired;
  logic [DT_W-1:0] dt_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PWM_DT_OFF;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      pwm_q   <= pwm_in;
    end
  end

  // NOTE: every variable written in this block gets its default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state_q;
    if (fault_in) begin
      state_next = PWM_DT_FAULT;
    end else if (!en && state_q != PWM_DT_FAULT) begin
      state_next = PWM_DT_OFF;
    end else begin
      case (state_q)
        PWM_DT_OFF:   state_next = pwm_q ? PWM_DT_TO_HS : PWM_DT_TO_LS;
        PWM_DT_TO_HS,
        PWM_DT_TO_LS: if (dt_expired) state_next = pwm_q ? PWM_DT_HS_ON : PWM_DT_LS_ON;
        PWM_DT_HS_ON: if (!pwm_q) state_next = PWM_DT_TO_LS;
        PWM_DT_LS_ON: if (pwm_q) state_next = PWM_DT_TO_HS;
        PWM_DT_FAULT: if (fault_clr) state_next = PWM_DT_OFF;
        default:      state_next = PWM_DT_OFF;
      endcase
    end
  end

  // A dead time of zero would let one side rise on the same edge the other
  // falls, so zero is widened to a single cycle.
  assign dt_value = (dead_cycles == '0) ? '0 : dead_cycles - DT_W'(1);
  assign dt_load  = (state_next == PWM_DT_TO_HS || state_next == PWM_DT_TO_LS) &&
                    (state_next != state_q);

  dt_timer #(
    .DT_W (DT_W)
  ) u_dt_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dt_load),
    .value   (dt_value),
    .expired (dt_expired)
  );

  assign hs_out     = state_q[PWM_DT_HS_ON_BIT];
  assign ls_out     = state_q[PWM_DT_LS_ON_BIT];
  assign dt_active  = state_q[PWM_DT_TO_HS_BIT] | state_q[PWM_DT_TO_LS_BIT];
  assign fault_flag = state_q[PWM_DT_FAULT_BIT];

endmodule
